// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Round-robin arbiter sharing one 32x32 register-file read port among
//   NUM_REQ requesters. Each granted read drives the mux select, captures
//   the mux output one cycle later and returns it with a one-cycle valid
//   pulse to the winning requester.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   req        : per-requester level-sensitive read request
//   addr_flat  : requester i address at [5*i +: 5]
//   mux_select : registered select to the 32:1 read mux
//   mux_data   : combinational mux output for the current mux_select
//   grant      : registered one-hot of the requester being served
//   rsp_valid  : one-cycle one-hot response pulse
//   rsp_data   : captured read data, holds until the next capture
//   busy       : high whenever a read is in flight
//
// state | meaning
// IDLE  | no read in flight
// READ  | mux_select applied, mux data settling
// RESP  | rsp_valid pulsing, next winner may be launched

module regfile_read_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [5*NUM_REQ-1:0]   addr_flat,
    output logic [4:0]             mux_select,
    input  logic [31:0]            mux_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   busy
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      ptr_next;
    int                 idx;

    // In RESP the served requester still holds req for this cycle, so it
    // is masked out to avoid granting the same read twice.
    assign eligible = (state == RESP) ? (req & ~grant) : req;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    assign ptr_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            mux_select <= '0;
            grant      <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mux_select <= addr_flat[5*win_idx +: 5];
                        grant      <= NUM_REQ'(1) << win_idx;
                        ptr        <= ptr_next;
                        state      <= READ;
                        busy       <= 1'b1;
                    end
                end
                READ: begin
                    rsp_data  <= mux_data;
                    rsp_valid <= grant;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    if (found) begin
                        mux_select <= addr_flat[5*win_idx +: 5];
                        grant      <= NUM_REQ'(1) << win_idx;
                        ptr        <= ptr_next;
                        state      <= READ;
                    end else begin
                        grant <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
